// File: rtl/mod_add_ctrl.sv
// Modular add/subtract sequencer for 512-bit operands.
// Drives a shared multi-cycle 513-bit adder: the first adder pass forms a+b
// or a-b, and an optional second pass applies the modulus correction.
// The raw adder results are kept in res_q; its low DATA_W bits are the
// visible result once done pulses.
module mod_add_ctrl #(
    parameter int DATA_W = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                subtract,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic [DATA_W-1:0]   in_m,
    output logic [DATA_W-1:0]   result,
    output logic                done,
    output logic                busy,
    output logic                add_start,
    output logic                add_subtract,
    output logic [DATA_W:0]     add_in_a,
    output logic [DATA_W:0]     add_in_b,
    input  logic [DATA_W+1:0]   add_result,
    input  logic                add_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE1 = 3'd1;
    localparam logic [2:0] S_WAIT1  = 3'd2;
    localparam logic [2:0] S_ISSUE2 = 3'd3;
    localparam logic [2:0] S_WAIT2  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [DATA_W-1:0]  m_q, m_d;
    logic               sub_q, sub_d;
    logic [DATA_W+1:0]  res_q, res_d;
    logic               asub_q, asub_d;
    logic [DATA_W:0]    ain_q, ain_d;
    logic [DATA_W:0]    bin_q, bin_d;

    // Next-state and operand sequencing: pass 1 uses the latched a/b,
    // pass 2 feeds the pass-1 result back against the modulus.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        sub_d   = sub_q;
        res_d   = res_q;
        asub_d  = asub_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE1;
                    m_d     = in_m;
                    sub_d   = subtract;
                    asub_d  = subtract;
                    ain_d   = {1'b0, in_a};
                    bin_d   = {1'b0, in_b};
                end
            end
            S_ISSUE1: state_d = S_WAIT1;
            S_WAIT1: begin
                if (add_done) begin
                    res_d = add_result;
                    // Add always needs the trial subtraction of m; subtract
                    // only needs +m when a-b went negative.
                    if (!sub_q || add_result[DATA_W+1]) begin
                        state_d = S_ISSUE2;
                        asub_d  = ~sub_q;
                        ain_d   = add_result[DATA_W:0];
                        bin_d   = {1'b0, m_q};
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE2: state_d = S_WAIT2;
            S_WAIT2: begin
                if (add_done) begin
                    state_d = S_DONE;
                    // A negative s-m means s was already reduced: keep s.
                    if (!sub_q && add_result[DATA_W+1]) begin
                        res_d = res_q;
                    end else begin
                        res_d = add_result;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything so the adder
    // interface goes quiet immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            asub_q  <= 1'b0;
            ain_q   <= '0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            asub_q  <= asub_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
        end
    end

    assign add_start    = (state_q == S_ISSUE1) || (state_q == S_ISSUE2);
    assign add_subtract = asub_q;
    assign add_in_a     = ain_q;
    assign add_in_b     = bin_q;
    assign done         = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign result       = res_q[DATA_W-1:0];

endmodule
